// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - ID/EX-side handshake and result bundle for the M-extension unit
interface ex_muldiv_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - Iterative RV32M multiply/divide unit for the execute stage
module ex_muldiv_unit (
  input  logic            clk,
  input  logic            reset,
  ex_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_funct3;
  logic        r_neg_a;
  logic        r_neg_b;
  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic [63:0] r_acc;
  logic [4:0]  r_count;
  logic [31:0] r_result;

  logic        w_is_div;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_special;
  logic [31:0] w_special_val;
  logic        w_accept;
  logic        w_iterate;

  logic [32:0] w_mul_sum;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [63:0] w_acc_step;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_final;

  logic        w_load_result;
  logic [31:0] w_result_nxt;

  assign w_is_div   = bus.funct3[2];
  assign w_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign w_b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
  assign w_neg_a    = w_a_signed & bus.op_a[31];
  assign w_neg_b    = w_b_signed & bus.op_b[31];
  assign w_mag_a    = w_neg_a ? (32'd0 - bus.op_a) : bus.op_a;
  assign w_mag_b    = w_neg_b ? (32'd0 - bus.op_b) : bus.op_b;

  assign w_div_zero = w_is_div && (bus.op_b == 32'd0);
  assign w_div_ovf  = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                      (bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero || w_div_ovf;

  always_comb begin
    w_special_val = 32'd0;
    if (w_div_zero) begin
      w_special_val = bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF;
    end else if (w_div_ovf) begin
      w_special_val = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  assign w_accept  = (r_state == S_IDLE) && bus.start && !bus.flush;
  assign w_iterate = (r_state == S_BUSY) && !bus.flush;

  // Multiply: acc = {partial_hi, multiplier}; add multiplicand on lsb then shift right.
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);

  // Divide: acc = {remainder, dividend->quotient}; shift left, trial subtract.
  assign w_rem_sh  = {r_acc[63:32], r_acc[31]};
  assign w_diff    = w_rem_sh - {1'b0, r_mag_b};

  always_comb begin
    w_acc_step = r_acc;
    if (r_funct3[2]) begin
      if (w_diff[32]) begin
        w_acc_step = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
      end else begin
        w_acc_step = {w_diff[31:0], r_acc[30:0], 1'b1};
      end
    end else begin
      w_acc_step = {w_mul_sum, r_acc[31:1]};
    end
  end

  assign w_prod = (r_neg_a ^ r_neg_b) ? (64'd0 - w_acc_step) : w_acc_step;
  assign w_quot = (r_neg_a ^ r_neg_b) ? (32'd0 - w_acc_step[31:0]) : w_acc_step[31:0];
  assign w_rem  = r_neg_a ? (32'd0 - w_acc_step[63:32]) : w_acc_step[63:32];

  always_comb begin
    w_final = 32'd0;
    if (!r_funct3[2]) begin
      w_final = (r_funct3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
    end else begin
      w_final = r_funct3[1] ? w_rem : w_quot;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_result = 1'b0;
    w_result_nxt  = r_result;
    case (r_state)
      S_IDLE: begin
        if (!bus.flush && bus.start) begin
          if (w_special) begin
            w_state_nxt   = S_DONE;
            w_load_result = 1'b1;
            w_result_nxt  = w_special_val;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_count == 5'd31) begin
          w_state_nxt   = S_DONE;
          w_load_result = 1'b1;
          w_result_nxt  = w_final;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_funct3 <= 3'd0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_mag_a  <= 32'd0;
      r_mag_b  <= 32'd0;
      r_acc    <= 64'd0;
      r_count  <= 5'd0;
      r_result <= 32'd0;
    end else begin
      if (w_accept) begin
        r_funct3 <= bus.funct3;
        r_neg_a  <= w_neg_a;
        r_neg_b  <= w_neg_b;
        r_mag_a  <= w_mag_a;
        r_mag_b  <= w_mag_b;
        r_acc    <= {32'd0, (w_is_div ? w_mag_a : w_mag_b)};
        r_count  <= 5'd0;
      end else if (w_iterate) begin
        r_acc   <= w_acc_step;
        r_count <= r_count + 5'd1;
      end
      if (w_load_result) begin
        r_result <= w_result_nxt;
      end
    end
  end

  assign bus.stall  = bus.start && (r_state != S_DONE);
  assign bus.busy   = (r_state == S_BUSY);
  assign bus.done   = (r_state == S_DONE) && !bus.flush;
  assign bus.result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - Scoreboard bench for ex_muldiv_unit with a plain-arithmetic reference
module tb_ex_muldiv_unit;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [63:0]     w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    w  = 64'd0;
    case (f)
      3'b000: begin up = ua * ub; w = up; return w[31:0]; end
      3'b001: begin sp = sa * sb; w = sp; return w[63:32]; end
      3'b010: begin sp = sa * longint'(ub); w = sp; return w[63:32]; end
      3'b011: begin up = ua * ub; w = up; return w[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; w = sp; return w[31:0];
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; w = sp; return w[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0)) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", bus.result, e.res);
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk("stall_at_done", 32'(bus.stall), 32'd0);
      end
    end
  end

  task automatic idle_gap(input int k);
    bus.start = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit b2b);
    logic [31:0] exp;
    int          lat;
    int          n;
    exp = ref_model(f, a, b);
    lat = lat_of(f, a, b);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    #1;
    if (b2b) @(negedge clk);
    chk("busy_at_accept", 32'(bus.busy), 32'd0);
    chk("result_hold", bus.result, last_res);
    sb_q.push_back('{exp, cyc + lat});
    n = 0;
    while (bus.stall === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
      if (n == 1) chk("busy_after_accept", 32'(bus.busy), (lat == 33) ? 32'd1 : 32'd0);
    end
    chk("stall_cycles", 32'(n), 32'(lat));
    last_res = exp;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    bit          b2b;
  } dir_t;

  dir_t dir[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    n_cmp    = 0;
    n_fail   = 0;
    cyc      = 0;
    last_res = 32'd0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd0;
    bus.op_b   = 32'd0;
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    dir.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 1'b0});
    dir.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1});
    dir.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 1'b1});
    dir.push_back('{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0});
    dir.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         1'b1});
    dir.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         1'b1});
    dir.push_back('{3'b101, 32'd100,        32'd7,         1'b0});
    dir.push_back('{3'b111, 32'd100,        32'd7,         1'b1});
    dir.push_back('{3'b101, 32'd100,        32'd0,         1'b1});
    dir.push_back('{3'b110, 32'hFFFF_FFF9,  32'd0,         1'b1});
    dir.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0});
    dir.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1});
    dir.push_back('{3'b000, 32'd3,          32'd5,         1'b1});

    foreach (dir[i]) begin
      if (!dir[i].b2b) idle_gap(i == 0 ? 0 : 2);
      do_op(dir[i].f, dir[i].a, dir[i].b, dir[i].b2b);
    end

    // Flush a DIV at cycle 10, then start MUL 3x5 at cycle 12.
    idle_gap(2);
    bus.start  = 1'b1;
    bus.funct3 = 3'b100;
    bus.op_a   = 32'd1000;
    bus.op_b   = 32'd7;
    c0 = cyc;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_done", 32'(bus.done), 32'd0);
    chk("flush_result", bus.result, last_res);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("flush_restart_cycle", 32'(cyc - c0), 32'd12);
    do_op(3'b000, 32'd3, 32'd5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      bit b2b;
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) idle_gap($urandom_range(1, 3));
      do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), b2b);
    end

    // Asynchronous reset in the middle of a multiply.
    idle_gap(2);
    bus.start  = 1'b1;
    bus.funct3 = 3'b011;
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 32'(bus.busy), 32'd0);
    chk("async_reset_done", 32'(bus.done), 32'd0);
    chk("async_reset_result", bus.result, 32'd0);
    chk("async_reset_stall", 32'(bus.stall), 32'd1);
    bus.start = 1'b0;
    #1;
    chk("async_reset_stall_idle", 32'(bus.stall), 32'd0);
    last_res = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(3'b000, 32'd3, 32'd5, 1'b0);
    do_op(3'b000, 32'hFFFF_FFFF, 32'd2, 1'b1);

    idle_gap(4);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
